// File: rtl/mem_fill_responder_pkg.sv
// mem_fill_responder_pkg: shared constants and the pipeline stage record for the fill responder
//   MEM_LATENCY    default request-to-response latency in cycles
//   MEM_WORD_W     width of one stored word
//   MEM_DEPTH_LOG2 default log2 of the number of stored words
//   FILL_WORDS     cache block size in words, one fill burst
//   stage_t        valid flag plus data word carried by one pipeline stage
package mem_fill_responder_pkg;
   localparam int MEM_LATENCY    = 4;
   localparam int MEM_WORD_W     = 16;
   localparam int MEM_DEPTH_LOG2 = 15;
   localparam int FILL_WORDS     = 8;
   typedef struct packed {
      logic                  valid;
      logic [MEM_WORD_W-1:0] data;
   } stage_t;
endpackage

// File: rtl/mem_pipe_stage.sv
// mem_pipe_stage: one valid+data register of the read response pipeline
//   clk      system clock
//   rst_n    synchronous active-low clear of valid and data
//   i_stage  record entering this stage
//   o_stage  record held by this stage
module mem_pipe_stage
   import mem_fill_responder_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  stage_t i_stage,
   output stage_t o_stage
);
   stage_t r_stage;
   always_ff @(posedge clk) begin
      if (!rst_n) r_stage <= '0;
      else        r_stage <= i_stage;
   end
   assign o_stage = r_stage;
endmodule

// File: rtl/mem_fill_responder.sv
// mem_fill_responder: pipelined word memory answering cache fill reads after a fixed latency
//   clk             system clock
//   rst_n           synchronous active-low reset of the response pipeline
//   enable          request valid this cycle
//   wr              1 = write, 0 = read (with enable)
//   mem_address     byte address, bit 0 ignored, upper bits alias
//   data_in         write data
//   data_out        read data, meaningful while mem_data_valid is high
//   mem_data_valid  response to the read issued LATENCY cycles earlier
//   busy            at least one read in flight
module mem_fill_responder
   import mem_fill_responder_pkg::*;
#(
   parameter int LATENCY    = MEM_LATENCY,
   parameter int ADDR_W     = 16,
   parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  wr,
   input  logic [ADDR_W-1:0]     mem_address,
   input  logic [MEM_WORD_W-1:0] data_in,
   output logic [MEM_WORD_W-1:0] data_out,
   output logic                  mem_data_valid,
   output logic                  busy
);
   localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(((1 << DEPTH_LOG2) - 1) << 1);
   logic [MEM_WORD_W-1:0] r_mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] w_idx;
   logic                  w_we;
   logic                  w_rd;
   logic                  w_unused;
   stage_t [LATENCY:0]    w_stage;
   assign w_idx    = mem_address[DEPTH_LOG2:1];
   // byte-select bit and aliasing upper bits are deliberately dropped
   assign w_unused = ^(mem_address & ~IDX_MASK);
   // a write presented during reset must not touch the array
   assign w_we     = enable & wr & rst_n;
   assign w_rd     = enable & ~wr;
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_idx] <= data_in;
   end
   // the word is snapshotted at issue; bubbles carry zero data
   assign w_stage[0].valid = w_rd;
   assign w_stage[0].data  = w_rd ? r_mem[w_idx] : '0;
   for (genvar g = 0; g < LATENCY; g++) begin : g_pipe
      mem_pipe_stage u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_stage (w_stage[g]),
         .o_stage (w_stage[g+1])
      );
   end
   assign data_out       = w_stage[LATENCY].data;
   assign mem_data_valid = w_stage[LATENCY].valid;
   always_comb begin
      busy = 1'b0;
      for (int i = 1; i <= LATENCY; i++) busy = busy | w_stage[i].valid;
   end
endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: table, directed and random checks of mem_fill_responder against a latency scoreboard
module tb_mem_fill_responder;
   import mem_fill_responder_pkg::*;
   localparam int L  = MEM_LATENCY;
   localparam int AW = 16;
   localparam int D  = 8;
   localparam int NW = 1 << D;
   localparam int NS = 4096;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        wr = 1'b0;
   logic [15:0] mem_address = '0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic        mem_data_valid;
   logic        busy;
   always #5 clk = ~clk;
   mem_fill_responder #(.LATENCY(L), .ADDR_W(AW), .DEPTH_LOG2(D)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .wr             (wr),
      .mem_address    (mem_address),
      .data_in        (data_in),
      .data_out       (data_out),
      .mem_data_valid (mem_data_valid),
      .busy           (busy)
   );
   logic [15:0] m_mem [NW];
   bit          s_v [NS];
   logic [15:0] s_d [NS];
   int          k = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   typedef struct {
      logic        en;
      logic        wr;
      logic [15:0] a;
      logic [15:0] d;
      logic        ev;
      logic [15:0] ed;
   } vec_t;
   vec_t tv [32];
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, k, act, exp);
      end
   endtask
   // drive one request, advance one edge, update the scoreboard and compare
   task automatic cyc(input logic r, input logic e, input logic w, input logic [15:0] a, input logic [15:0] dd);
      bit b;
      rst_n = r; enable = e; wr = w; mem_address = a; data_in = dd;
      @(posedge clk);
      #1;
      k++;
      if (!r) for (int i = k; i <= k + L; i++) s_v[i] = 1'b0;
      else if (e && w) m_mem[(a >> 1) % NW] = dd;
      else if (e) begin
         s_v[k+L-1] = 1'b1;
         s_d[k+L-1] = m_mem[(a >> 1) % NW];
      end
      b = 1'b0;
      for (int i = k; i < k + L; i++) b = b | s_v[i];
      chk("model_valid", {15'd0, mem_data_valid}, {15'd0, s_v[k]});
      chk("model_busy", {15'd0, busy}, {15'd0, b});
      if (s_v[k]) chk("model_data", data_out, s_d[k]);
   endtask
   initial begin
      logic [15:0] x;
      repeat (2) begin
         cyc(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
         chk("rst_data", data_out, 16'h0);
      end
      repeat (L) begin
         cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
         chk("rel_data", data_out, 16'h0);
      end
      for (int i = 0; i < NW; i++) cyc(1'b1, 1'b1, 1'b1, 16'(i * 2), 16'($urandom));
      cyc(1'b1, 1'b1, 1'b1, 16'h0040, 16'hBEEF);
      cyc(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0);
      chk("single_busy0", {15'd0, busy}, 16'd1);
      for (int j = 0; j < L; j++) begin
         cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
         chk("single_valid", {15'd0, mem_data_valid}, {15'd0, j == L - 2});
         chk("single_busy", {15'd0, busy}, {15'd0, j <= L - 2});
         if (j == L - 2) chk("single_data", data_out, 16'hBEEF);
      end
      for (int i = 0; i < 32; i++) tv[i] = '{1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0};
      for (int i = 0; i < FILL_WORDS; i++) begin
         tv[i]                  = '{1'b1, 1'b1, 16'(16'h0100 + 2 * i), 16'(16'h1000 + i), 1'b0, 16'h0};
         tv[FILL_WORDS+i]       = '{1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'h0, 1'b0, 16'h0};
      end
      for (int i = 0; i < FILL_WORDS; i++) begin
         tv[FILL_WORDS+i+L-1].ev = 1'b1;
         tv[FILL_WORDS+i+L-1].ed = 16'(16'h1000 + i);
      end
      tv[19] = '{1'b1, 1'b1, 16'h0200, 16'hA5A5, 1'b0, 16'h0};
      tv[20] = '{1'b1, 1'b0, 16'h0200, 16'h0, 1'b0, 16'h0};
      tv[21] = '{1'b1, 1'b1, 16'h0200, 16'h5A5A, 1'b0, 16'h0};
      tv[22] = '{1'b1, 1'b0, 16'h0200, 16'h0, 1'b0, 16'h0};
      tv[20+L-1].ev = 1'b1; tv[20+L-1].ed = 16'hA5A5;
      tv[22+L-1].ev = 1'b1; tv[22+L-1].ed = 16'h5A5A;
      for (int i = 0; i < 26; i++) begin
         cyc(1'b1, tv[i].en, tv[i].wr, tv[i].a, tv[i].d);
         chk("tbl_valid", {15'd0, mem_data_valid}, {15'd0, tv[i].ev});
         if (tv[i].ev) chk("tbl_data", data_out, tv[i].ed);
      end
      for (int j = 0; j < 6; j++) cyc(1'b1, 1'b1, 1'b0, 16'(16'h0100 + 2 * j), 16'h0);
      cyc(1'b0, 1'b1, 1'b0, 16'h010C, 16'h0);
      chk("midrst_valid", {15'd0, mem_data_valid}, 16'd0);
      for (int j = 0; j < L; j++) begin
         cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
         chk("midrst_after", {15'd0, mem_data_valid}, 16'd0);
      end
      cyc(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0);
      repeat (L - 1) cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      chk("post_rst_valid", {15'd0, mem_data_valid}, 16'd1);
      chk("post_rst_data", data_out, 16'h1000);
      x = 16'($urandom);
      cyc(1'b1, 1'b1, 1'b1, 16'h0002, x);
      for (int j = 0; j < L + 2; j++) begin
         cyc(1'b1, j == 0 || j == 2, 1'b0, j == 0 ? 16'h0202 : 16'h0002, 16'h0);
         if (j >= L - 1) begin
            chk("alias_valid", {15'd0, mem_data_valid}, {15'd0, j != L});
            if (j != L) chk("alias_data", data_out, x);
         end
      end
      for (int i = 0; i < 1500; i++)
         cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
             16'($urandom), 16'($urandom));
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
